// File: rtl/uart_stop_watch_report.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_stop_watch_report : snapshots stopwatch status/time, sends a 12-byte
// ASCII frame "S HH:MM.LL\r\n" one byte at a time to a UART.     Rev 1.0
// ----------------------------------------------------------------------------
module uart_stop_watch_report #(
  parameter int AUTO_REPORT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       report_req,
  input  logic       mode_flag,
  input  logic       run_stop_flag,
  input  logic       clear_flag,
  input  logic [6:0] t_hi,
  input  logic [6:0] t_mid,
  input  logic [6:0] t_lo,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD    = 3'd1;
  localparam logic [2:0] SEND    = 3'd2;
  localparam logic [2:0] WAIT_HI = 3'd3;
  localparam logic [2:0] WAIT_LO = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  localparam logic [1:0] STAT_C = 2'd0;
  localparam logic [1:0] STAT_R = 2'd1;
  localparam logic [1:0] STAT_S = 2'd2;
  localparam logic [1:0] STAT_Z = 2'd3;

  localparam logic [3:0] LAST_IDX = 4'd11;

  // Saturate to 99, then split into {tens, ones} BCD nibbles.
  function automatic logic [7:0] to_digits(input logic [6:0] value);
    logic [6:0] sat;
    logic [3:0] tens;
    sat  = (value > 7'd99) ? 7'd99 : value;
    tens = 4'd0;
    for (int k = 1; k <= 9; k++) begin
      if (sat >= 7'(k * 10)) tens = 4'(k);
    end
    return {tens, 4'(sat - ({3'b000, tens} * 7'd10))};
  endfunction

  logic [2:0] state_q, state_d;
  logic [1:0] status_code;
  logic [1:0] prev_status_q;
  logic       pending_q;
  logic [3:0] index_q;
  logic [1:0] snap_status_q;
  logic [7:0] snap_hi_q, snap_mid_q, snap_lo_q;
  logic [7:0] tx_data_q;
  logic       tx_start_q;
  logic [7:0] cur_byte;
  logic       status_change;
  logic       ext_trigger;
  logic       trigger;
  logic       send_fire;

  always_comb begin
    if (clear_flag) begin
      status_code = STAT_Z;
    end else if (!mode_flag) begin
      status_code = STAT_C;
    end else if (run_stop_flag) begin
      status_code = STAT_R;
    end else begin
      status_code = STAT_S;
    end
  end

  assign status_change = (AUTO_REPORT != 0) && (status_code != prev_status_q);
  assign ext_trigger   = report_req | status_change;
  assign trigger       = ext_trigger | pending_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (trigger) state_d = LOAD;
      LOAD:    state_d = SEND;
      SEND:    if (!tx_busy) state_d = WAIT_HI;
      WAIT_HI: if (tx_busy) state_d = WAIT_LO;
      WAIT_LO: begin
        if (!tx_busy) state_d = (index_q == LAST_IDX) ? DONE : SEND;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != IDLE);
    frame_done = (state_q == DONE);
    send_fire  = (state_q == SEND) && !tx_busy;
  end

  always_comb begin
    cur_byte = 8'h00;
    case (index_q)
      4'd0: begin
        case (snap_status_q)
          STAT_Z:  cur_byte = 8'h5A;
          STAT_R:  cur_byte = 8'h52;
          STAT_S:  cur_byte = 8'h53;
          default: cur_byte = 8'h43;
        endcase
      end
      4'd1:    cur_byte = 8'h20;
      4'd2:    cur_byte = {4'h3, snap_hi_q[7:4]};
      4'd3:    cur_byte = {4'h3, snap_hi_q[3:0]};
      4'd4:    cur_byte = 8'h3A;
      4'd5:    cur_byte = {4'h3, snap_mid_q[7:4]};
      4'd6:    cur_byte = {4'h3, snap_mid_q[3:0]};
      4'd7:    cur_byte = 8'h2E;
      4'd8:    cur_byte = {4'h3, snap_lo_q[7:4]};
      4'd9:    cur_byte = {4'h3, snap_lo_q[3:0]};
      4'd10:   cur_byte = 8'h0D;
      4'd11:   cur_byte = 8'h0A;
      default: cur_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_status_q <= STAT_C;
      pending_q     <= 1'b0;
      index_q       <= 4'd0;
      snap_status_q <= STAT_C;
      snap_hi_q     <= 8'h00;
      snap_mid_q    <= 8'h00;
      snap_lo_q     <= 8'h00;
      tx_data_q     <= 8'h00;
      tx_start_q    <= 1'b0;
    end else begin
      prev_status_q <= status_code;
      // IDLE always accepts the trigger, so any pending request is consumed there.
      if (state_q == IDLE) begin
        pending_q <= 1'b0;
      end else if (ext_trigger) begin
        pending_q <= 1'b1;
      end
      if (state_q == LOAD) begin
        snap_status_q <= status_code;
        snap_hi_q     <= to_digits(t_hi);
        snap_mid_q    <= to_digits(t_mid);
        snap_lo_q     <= to_digits(t_lo);
        index_q       <= 4'd0;
      end else if ((state_q == WAIT_LO) && !tx_busy && (index_q != LAST_IDX)) begin
        index_q <= index_q + 4'd1;
      end
      tx_start_q <= send_fire;
      if (send_fire) begin
        tx_data_q <= cur_byte;
      end
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;

endmodule
`default_nettype wire
